// File: rtl/ddr3_cmd_arb.sv
// ddr3_cmd_arb: READ/WRITE/REFRESH command arbiter for a DDR3 data-link layer with postponed-refresh tracking.
// Define DDR3_ARB_ROUND_ROBIN_EN to alternate read/write grants; otherwise reads win.
module ddr3_cmd_arb #(
  parameter int DDR_FREQ_MHZ = 100,
  parameter int DDR_TREFI    = 7800,
  parameter int DDR_ROW_BITS = 13,
  parameter int REF_MAX_PEND = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rd_req_i,
  input  logic [2:0]              rd_bank_i,
  input  logic [DDR_ROW_BITS-1:0] rd_addr_i,
  output logic                    rd_ack_o,
  input  logic                    wr_req_i,
  input  logic [2:0]              wr_bank_i,
  input  logic [DDR_ROW_BITS-1:0] wr_addr_i,
  output logic                    wr_ack_o,
  output logic                    ddl_req_o,
  output logic [3:0]              ddl_cmd_o,
  output logic [2:0]              ddl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
  input  logic                    ddl_rdy_i,
  output logic [3:0]              ref_pend_o,
  output logic                    ref_ovr_o
);
  localparam int          CREFI_I = DDR_TREFI * DDR_FREQ_MHZ / 1000 - 1;
  localparam logic [15:0] CREFI   = 16'(CREFI_I);
  localparam logic [3:0]  PMAX    = 4'(REF_MAX_PEND);
  localparam logic [3:0]  C_READ  = 4'b0101;
  localparam logic [3:0]  C_WRIT  = 4'b0100;
  localparam logic [3:0]  C_REFR  = 4'b0001;
  localparam logic [3:0]  C_NOOP  = 4'b0111;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRIT, ST_REFR} state_t;

  state_t                  r_state, w_next;
  logic [15:0]             r_timer;
  logic [3:0]              r_pend;
  logic                    r_ovr;
  logic [2:0]              r_ba;
  logic [DDR_ROW_BITS-1:0] r_adr;
  logic                    w_expire, w_sat, w_refr_acc, w_rd_first, w_grant_rd, w_grant_wr;

  assign w_expire   = r_timer == 16'd0;
  assign w_sat      = r_pend == PMAX;
  assign w_refr_acc = r_state == ST_REFR && ddl_rdy_i;
  assign w_grant_rd = r_state == ST_IDLE && w_next == ST_READ;
  assign w_grant_wr = r_state == ST_IDLE && w_next == ST_WRIT;

`ifdef DDR3_ARB_ROUND_ROBIN_EN
  logic r_wr_turn;
  assign w_rd_first = !r_wr_turn;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_wr_turn <= 1'b0;
    else if (w_grant_rd || w_grant_wr) r_wr_turn <= !r_wr_turn;
`else
  assign w_rd_first = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_next;

  // An issued command is never abandoned; even a saturated refresh waits for acceptance.
  always_comb begin
    w_next = r_state;
    if (r_state != ST_IDLE) w_next = ddl_rdy_i ? ST_IDLE : r_state;
    else if (w_sat) w_next = ST_REFR;
    else if (rd_req_i && (w_rd_first || !wr_req_i)) w_next = ST_READ;
    else if (wr_req_i) w_next = ST_WRIT;
    else if (r_pend != 4'd0) w_next = ST_REFR;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_timer <= CREFI;
      r_pend  <= 4'd0;
      r_ovr   <= 1'b0;
      r_ba    <= 3'd0;
      r_adr   <= '0;
    end else begin
      r_timer <= w_expire ? CREFI : r_timer - 16'd1;
      if (w_expire && w_sat) r_ovr <= 1'b1;
      if (w_expire != w_refr_acc) r_pend <= w_expire ? (w_sat ? r_pend : r_pend + 4'd1) : r_pend - 4'd1;
      if (w_grant_rd) begin
        r_ba  <= rd_bank_i;
        r_adr <= rd_addr_i;
      end else if (w_grant_wr) begin
        r_ba  <= wr_bank_i;
        r_adr <= wr_addr_i;
      end
    end

  assign ddl_req_o  = r_state != ST_IDLE;
  assign ddl_cmd_o  = r_state == ST_READ ? C_READ : r_state == ST_WRIT ? C_WRIT : r_state == ST_REFR ? C_REFR : C_NOOP;
  assign ddl_ba_o   = r_ba;
  assign ddl_adr_o  = r_adr;
  assign rd_ack_o   = r_state == ST_READ && ddl_rdy_i;
  assign wr_ack_o   = r_state == ST_WRIT && ddl_rdy_i;
  assign ref_pend_o = r_pend;
  assign ref_ovr_o  = r_ovr;
endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// tb_ddr3_cmd_arb: directed and randomized checks of ddr3_cmd_arb against a cycle-level behavioural model.
module tb_ddr3_cmd_arb;
  localparam int MAXP = 2;
  localparam int PER  = 10;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd_req, wr_req, rdy;
  logic [2:0]  rd_bank, wr_bank;
  logic [12:0] rd_addr, wr_addr;
  logic        rd_ack_o, wr_ack_o, ddl_req_o, ref_ovr_o;
  logic [3:0]  ddl_cmd_o, ref_pend_o;
  logic [2:0]  ddl_ba_o;
  logic [12:0] ddl_adr_o;

  int n_checks = 0;
  int n_errors = 0;

  int          m_cmd, m_pend, m_n, m_last;
  bit          m_ovr, m_ptr;
  logic [2:0]  m_ba;
  logic [12:0] m_adr;

  ddr3_cmd_arb #(.DDR_FREQ_MHZ(100), .DDR_TREFI(100), .DDR_ROW_BITS(13), .REF_MAX_PEND(MAXP)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req_i(rd_req), .rd_bank_i(rd_bank), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack_o),
    .wr_req_i(wr_req), .wr_bank_i(wr_bank), .wr_addr_i(wr_addr), .wr_ack_o(wr_ack_o),
    .ddl_req_o(ddl_req_o), .ddl_cmd_o(ddl_cmd_o), .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o),
    .ddl_rdy_i(rdy), .ref_pend_o(ref_pend_o), .ref_ovr_o(ref_ovr_o)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [3:0] code(int c);
    return c == 1 ? 4'b0101 : c == 2 ? 4'b0100 : c == 3 ? 4'b0001 : 4'b0111;
  endfunction

  task automatic model_reset();
    m_cmd = 0; m_pend = 0; m_n = 0; m_last = 0; m_ovr = 0; m_ptr = 0; m_ba = 0; m_adr = 0;
  endtask

  // Model: commands 0 idle, 1 read, 2 write, 3 refresh; refresh due every PER cycles after reset.
  task automatic cyc();
    bit ex, ra, rdw;
    @(posedge clock);
    ex = (m_n % PER) == PER - 1;
    m_n++;
    ra = m_cmd == 3 && rdy;
    m_last = 0;
    if (m_cmd != 0) begin
      if (rdy) begin
        m_last = m_cmd;
        m_cmd = 0;
      end
    end else begin
`ifdef DDR3_ARB_ROUND_ROBIN_EN
      rdw = !m_ptr;
`else
      rdw = 1'b1;
`endif
      if (m_pend == MAXP) m_cmd = 3;
      else if (rd_req && (rdw || !wr_req)) begin m_cmd = 1; m_ba = rd_bank; m_adr = rd_addr; m_ptr = !m_ptr; end
      else if (wr_req) begin m_cmd = 2; m_ba = wr_bank; m_adr = wr_addr; m_ptr = !m_ptr; end
      else if (m_pend > 0) m_cmd = 3;
    end
    if (ex && m_pend == MAXP) m_ovr = 1;
    if (ex && !ra) m_pend = m_pend < MAXP ? m_pend + 1 : MAXP;
    else if (ra && !ex) m_pend--;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 0; rd_req = 0; wr_req = 0; rdy = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; rd_req = 1; wr_req = 1; rdy = 1; rd_bank = 5; rd_addr = 13'h123; wr_bank = 6; wr_addr = 13'h0F0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (ddl_req_o !== 1'b0 || ddl_cmd_o !== 4'b0111) begin n_errors++; $display("FAIL reset_cmd: req=%b cmd=%b want req=0 cmd=0111", ddl_req_o, ddl_cmd_o); end
    n_checks++;
    if (ddl_ba_o !== 3'd0 || ddl_adr_o !== 13'd0) begin n_errors++; $display("FAIL reset_fields: ba=%0d adr=%h want 0 0", ddl_ba_o, ddl_adr_o); end
    n_checks++;
    if (rd_ack_o !== 1'b0 || wr_ack_o !== 1'b0) begin n_errors++; $display("FAIL reset_acks: rd=%b wr=%b want 0 0", rd_ack_o, wr_ack_o); end
    n_checks++;
    if (ref_pend_o !== 4'd0 || ref_ovr_o !== 1'b0) begin n_errors++; $display("FAIL reset_ref: pend=%0d ovr=%b want 0 0", ref_pend_o, ref_ovr_o); end
    rd_req = 0; wr_req = 0; rdy = 0;
    model_reset();
    reset_n = 1;
    for (int i = 0; i < PER; i++) begin
      n_checks++;
      if (ref_pend_o !== 4'd0) begin n_errors++; $display("FAIL timer_start cyc %0d: pend=%0d want 0", i, ref_pend_o); end
      cyc();
    end
    #1;
    n_checks++;
    if (ref_pend_o !== 4'd1) begin n_errors++; $display("FAIL timer_expiry: pend=%0d want 1", ref_pend_o); end
  endtask

  task automatic test_refresh();
    int last, cnt;
    do_reset();
    rdy = 1; last = -1; cnt = 0;
    for (int i = 0; i < 45; i++) begin
      #1;
      n_checks++;
      if (ref_pend_o !== 4'(m_pend)) begin n_errors++; $display("FAIL refresh_pend cyc %0d: pend=%0d want %0d", i, ref_pend_o, m_pend); end
      if (ddl_req_o) begin
        cnt++;
        n_checks++;
        if (ddl_cmd_o !== 4'b0001) begin n_errors++; $display("FAIL refresh_cmd cyc %0d: cmd=%b want 0001", i, ddl_cmd_o); end
        if (last >= 0) begin
          n_checks++;
          if (i - last != PER) begin n_errors++; $display("FAIL refresh_spacing: gap=%0d want %0d", i - last, PER); end
        end
        last = i;
      end
      cyc();
    end
    n_checks++;
    if (cnt != 4) begin n_errors++; $display("FAIL refresh_count: got=%0d want 4", cnt); end
  endtask

  task automatic test_back_to_back();
    int g[$];
    do_reset();
    rd_req = 1; rd_bank = 1; rd_addr = 13'h0AA;
    wr_req = 1; wr_bank = 2; wr_addr = 13'h111;
    rdy = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rd_ack_o) begin
        g.push_back(1);
        n_checks++;
        if (ddl_ba_o !== 3'd1 || ddl_adr_o !== 13'h0AA) begin n_errors++; $display("FAIL b2b_rd_fields: ba=%0d adr=%h want 1 0aa", ddl_ba_o, ddl_adr_o); end
      end
      if (wr_ack_o) begin
        g.push_back(2);
        n_checks++;
        if (ddl_ba_o !== 3'd2 || ddl_adr_o !== 13'h111) begin n_errors++; $display("FAIL b2b_wr_fields: ba=%0d adr=%h want 2 111", ddl_ba_o, ddl_adr_o); end
      end
      cyc();
    end
    rd_req = 0; wr_req = 0;
    n_checks++;
    if (g.size() != 6) begin n_errors++; $display("FAIL b2b_count: got=%0d want 6", g.size()); end
    for (int k = 0; k < 4 && k < g.size(); k++) begin
      int e;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
      e = (k % 2 == 1) ? 2 : 1;
`else
      e = 1;
`endif
      n_checks++;
      if (g[k] != e) begin n_errors++; $display("FAIL b2b_order grant %0d: got=%0d want %0d", k, g[k], e); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    wr_req = 1; wr_bank = 3; wr_addr = 13'h155; rdy = 0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (ddl_req_o !== 1'b1 || ddl_cmd_o !== 4'b0100 || ddl_ba_o !== 3'd3 || ddl_adr_o !== 13'h155 || wr_ack_o !== 1'b0)
        begin n_errors++; $display("FAIL stall_hold cyc %0d: req=%b cmd=%b ba=%0d adr=%h ack=%b want 1 0100 3 155 0", k, ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, wr_ack_o); end
      cyc();
    end
    rdy = 1;
    #1;
    n_checks++;
    if (wr_ack_o !== 1'b1 || rd_ack_o !== 1'b0) begin n_errors++; $display("FAIL stall_ack: wr=%b rd=%b want 1 0", wr_ack_o, rd_ack_o); end
    cyc();
    wr_req = 0;
    #1;
    n_checks++;
    if (wr_ack_o !== 1'b0 || ddl_req_o !== 1'b0) begin n_errors++; $display("FAIL stall_after: ack=%b req=%b want 0 0", wr_ack_o, ddl_req_o); end
  endtask

  task automatic test_overrun();
    do_reset();
    rdy = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      n_checks++;
      if (ref_pend_o !== 4'(m_pend) || ref_ovr_o !== m_ovr) begin n_errors++; $display("FAIL ovr_track cyc %0d: pend=%0d ovr=%b want %0d %b", i, ref_pend_o, ref_ovr_o, m_pend, m_ovr); end
      cyc();
    end
    #1;
    n_checks++;
    if (ref_pend_o !== 4'd2 || ref_ovr_o !== 1'b1) begin n_errors++; $display("FAIL ovr_sat: pend=%0d ovr=%b want 2 1", ref_pend_o, ref_ovr_o); end
    rdy = 1;
    for (int i = 0; i < 20; i++) cyc();
    #1;
    n_checks++;
    if (ref_ovr_o !== 1'b1 || ref_pend_o !== 4'(m_pend)) begin n_errors++; $display("FAIL ovr_sticky: ovr=%b pend=%0d want 1 %0d", ref_ovr_o, ref_pend_o, m_pend); end
  endtask

  task automatic test_priority();
    int g[$];
    do_reset();
    rd_req = 1; rd_bank = 4; rd_addr = 13'h0777; rdy = 0;
    for (int i = 0; i < 40 && m_pend != MAXP; i++) cyc();
    #1;
    n_checks++;
    if (ref_pend_o !== 4'd2 || ddl_cmd_o !== 4'b0101) begin n_errors++; $display("FAIL prio_setup: pend=%0d cmd=%b want 2 0101", ref_pend_o, ddl_cmd_o); end
    rdy = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rd_ack_o) g.push_back(1);
      if (ddl_req_o && ddl_cmd_o === 4'b0001) g.push_back(3);
      cyc();
    end
    rd_req = 0;
    n_checks++;
    if (g.size() < 3 || g[0] != 1 || g[1] != 3 || g[2] != 1)
      begin n_errors++; $display("FAIL prio_order: got %p want read,refresh,read first", g); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rd_req = 1; rd_bank = 7; rd_addr = 13'h1ABC; rdy = 0;
    cyc();
    #1;
    n_checks++;
    if (ddl_req_o !== 1'b1 || ddl_cmd_o !== 4'b0101) begin n_errors++; $display("FAIL mid_pre: req=%b cmd=%b want 1 0101", ddl_req_o, ddl_cmd_o); end
    #2;
    rdy = 1;
    reset_n = 0;
    #1;
    n_checks++;
    if (ddl_req_o !== 1'b0 || rd_ack_o !== 1'b0 || wr_ack_o !== 1'b0 || ddl_cmd_o !== 4'b0111)
      begin n_errors++; $display("FAIL mid_drop: req=%b rack=%b wack=%b cmd=%b want 0 0 0 0111", ddl_req_o, rd_ack_o, wr_ack_o, ddl_cmd_o); end
    n_checks++;
    if (ddl_ba_o !== 3'd0 || ddl_adr_o !== 13'd0 || ref_pend_o !== 4'd0 || ref_ovr_o !== 1'b0)
      begin n_errors++; $display("FAIL mid_regs: ba=%0d adr=%h pend=%0d ovr=%b want 0 0 0 0", ddl_ba_o, ddl_adr_o, ref_pend_o, ref_ovr_o); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      rdy = $urandom_range(0, 3) < (i < 800 ? 3 : 1);
      #1;
      n_checks++;
      if (ddl_req_o !== (m_cmd != 0) || ddl_cmd_o !== code(m_cmd) || rd_ack_o !== (m_cmd == 1 && rdy) ||
          wr_ack_o !== (m_cmd == 2 && rdy) || ref_pend_o !== 4'(m_pend) || ref_ovr_o !== m_ovr ||
          ((m_cmd == 1 || m_cmd == 2) && (ddl_ba_o !== m_ba || ddl_adr_o !== m_adr)))
        begin
          n_errors++;
          $display("FAIL random cyc %0d: got req=%b cmd=%b ba=%0d adr=%h rack=%b wack=%b pend=%0d ovr=%b; want cmd=%b ba=%0d adr=%h pend=%0d ovr=%b",
                   i, ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, rd_ack_o, wr_ack_o, ref_pend_o, ref_ovr_o, code(m_cmd), m_ba, m_adr, m_pend, m_ovr);
        end
      cyc();
      if (m_last == 1) rd_req = 0;
      if (m_last == 2) wr_req = 0;
      if (!rd_req && $urandom_range(0, 1) == 1) begin rd_req = 1; rd_bank = 3'($urandom); rd_addr = 13'($urandom); end
      if (!wr_req && $urandom_range(0, 1) == 1) begin wr_req = 1; wr_bank = 3'($urandom); wr_addr = 13'($urandom); end
    end
    rd_req = 0; wr_req = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_refresh();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
